// File: rtl/bounce_updater_n.sv
// Per-frame colour-bounce state updater: edge-captured lane press, hit test, ball motion, score, sticky game-over.
// Latency 1 cycle from step to registered outputs; no backpressure, step may arrive every cycle.
// Optional macro BOUNCE_COMBO_EN: consecutive-hit combo scoring (default build adds 1 per hit).
module bounce_updater_n #(
    parameter int NUM_LANES  = 4,
    parameter int POS_W      = 8,
    parameter int COLOR_W    = 3,
    parameter int SCORE_W    = 16,
    parameter int SCREEN_H   = 160,
    parameter int HIT_WINDOW = 4,
    parameter int BOUNCE_LEN = 65
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic                         restart,
    input  logic [NUM_LANES-1:0]         keys,
    input  logic [POS_W-1:0]             curr_ball,
    input  logic [NUM_LANES*POS_W-1:0]   position_plats,
    input  logic [NUM_LANES*COLOR_W-1:0] color_plats,
    input  logic [COLOR_W-1:0]           color_ball,
    input  logic [SCORE_W-1:0]           curr_score,
    input  logic [NUM_LANES*COLOR_W-1:0] rand_plats,
    input  logic [COLOR_W-1:0]           rand_ball,
    output logic [POS_W-1:0]             prev_ball,
    output logic [POS_W-1:0]             new_curr_ball,
    output logic [NUM_LANES*COLOR_W-1:0] new_color_plats,
    output logic [COLOR_W-1:0]           new_color_ball,
    output logic [SCORE_W-1:0]           next_score,
    output logic                         gameover,
    output logic                         update_done,
    output logic                         rand_ack
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = $clog2(BOUNCE_LEN + 1);
    localparam logic [POS_W:0] SCREEN_LIM = (POS_W+1)'(SCREEN_H);
    localparam logic [POS_W:0] WIN_EXT    = (POS_W+1)'(HIT_WINDOW);

    typedef enum logic [1:0] {ST_FALL, ST_RISE, ST_OVER} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               up_cnt_q, up_cnt_d;
    logic [NUM_LANES-1:0]           key_q, key_d;
    logic                           pending_valid_q, pending_valid_d;
    logic [LANE_W-1:0]              pending_lane_q, pending_lane_d;
    logic [POS_W-1:0]               prev_ball_q, prev_ball_d;
    logic [POS_W-1:0]               new_curr_ball_q, new_curr_ball_d;
    logic [NUM_LANES*COLOR_W-1:0]   new_color_plats_q, new_color_plats_d;
    logic [COLOR_W-1:0]             new_color_ball_q, new_color_ball_d;
    logic [SCORE_W-1:0]             next_score_q, next_score_d;
    logic                           gameover_q, gameover_d;
    logic                           update_done_q, update_done_d;
    logic                           rand_ack_q, rand_ack_d;
`ifdef BOUNCE_COMBO_EN
    logic [3:0]                     combo_q, combo_d;
`endif

    logic [NUM_LANES-1:0] press;
    logic                 press_any;
    logic [LANE_W-1:0]    press_lane;
    logic                 active, restart_go, hit;
    logic [POS_W:0]       ball_ext, ball_nxt, plat_ext;
    logic [SCORE_W:0]     score_sum;
    logic [3:0]           score_inc;

    always_comb begin
        state_d           = state_q;
        up_cnt_d          = up_cnt_q;
        key_d             = keys;
        pending_valid_d   = pending_valid_q;
        pending_lane_d    = pending_lane_q;
        prev_ball_d       = prev_ball_q;
        new_curr_ball_d   = new_curr_ball_q;
        new_color_plats_d = new_color_plats_q;
        new_color_ball_d  = new_color_ball_q;
        next_score_d      = next_score_q;
        gameover_d        = gameover_q;
        update_done_d     = 1'b0;
        rand_ack_d        = 1'b0;
        press             = key_q & ~keys;
        press_any         = |press;
        press_lane        = '0;
        active            = step && (state_q != ST_OVER);
        restart_go        = restart && (state_q == ST_OVER);
        ball_ext          = {1'b0, curr_ball};
        ball_nxt          = ball_ext;
        plat_ext          = {1'b0, position_plats[pending_lane_q*POS_W +: POS_W]};
        score_inc         = 4'd1;
`ifdef BOUNCE_COMBO_EN
        combo_d           = combo_q;
        score_inc         = (combo_q >= 4'd8) ? 4'd8 : combo_q + 4'd1;
`endif
        score_sum         = {1'b0, curr_score} + (SCORE_W+1)'(score_inc);

        // Descending scan so the lowest falling lane is the one kept.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (press[i]) press_lane = LANE_W'(i);
        end

        hit = (state_q == ST_FALL) && pending_valid_q
           && (color_plats[pending_lane_q*COLOR_W +: COLOR_W] == color_ball)
           && (plat_ext >= ball_ext) && (plat_ext <= ball_ext + WIN_EXT);

        if (active) begin
            prev_ball_d       = curr_ball;
            update_done_d     = 1'b1;
            pending_valid_d   = 1'b0;
            new_color_plats_d = color_plats;
            new_color_ball_d  = color_ball;
            next_score_d      = curr_score;
            if (state_q == ST_FALL) begin
                ball_nxt = ball_ext + 1'b1;
            end else begin
                ball_nxt = (curr_ball == '0) ? ball_ext : ball_ext - 1'b1;
                up_cnt_d = up_cnt_q - 1'b1;
                if (up_cnt_q == CNT_W'(1)) state_d = ST_FALL;
            end
            new_curr_ball_d = ball_nxt[POS_W-1:0];

            if (ball_nxt >= SCREEN_LIM) begin
                gameover_d   = 1'b1;
                next_score_d = '0;
                state_d      = ST_OVER;
`ifdef BOUNCE_COMBO_EN
                combo_d      = 4'd0;
`endif
            end else if (hit) begin
                new_color_plats_d = rand_plats;
                new_color_ball_d  = rand_ball;
                rand_ack_d        = 1'b1;
                up_cnt_d          = CNT_W'(BOUNCE_LEN);
                state_d           = ST_RISE;
                next_score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`ifdef BOUNCE_COMBO_EN
                combo_d           = score_inc;
`endif
            end else if ((state_q == ST_FALL) && pending_valid_q) begin
`ifdef BOUNCE_COMBO_EN
                combo_d = 4'd0;
`endif
            end
        end

        // Capture sees the pre-step pending flag, so a same-cycle edge waits for the next step.
        if (press_any && !pending_valid_q) begin
            pending_valid_d = 1'b1;
            pending_lane_d  = press_lane;
        end

        if (restart_go) begin
            gameover_d      = 1'b0;
            pending_valid_d = 1'b0;
            state_d         = ST_FALL;
`ifdef BOUNCE_COMBO_EN
            combo_d         = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_FALL;
            up_cnt_q          <= '0;
            key_q             <= '0;
            pending_valid_q   <= 1'b0;
            pending_lane_q    <= '0;
            prev_ball_q       <= '0;
            new_curr_ball_q   <= '0;
            new_color_plats_q <= '0;
            new_color_ball_q  <= '0;
            next_score_q      <= '0;
            gameover_q        <= 1'b0;
            update_done_q     <= 1'b0;
            rand_ack_q        <= 1'b0;
`ifdef BOUNCE_COMBO_EN
            combo_q           <= 4'd0;
`endif
        end else begin
            state_q           <= state_d;
            up_cnt_q          <= up_cnt_d;
            key_q             <= key_d;
            pending_valid_q   <= pending_valid_d;
            pending_lane_q    <= pending_lane_d;
            prev_ball_q       <= prev_ball_d;
            new_curr_ball_q   <= new_curr_ball_d;
            new_color_plats_q <= new_color_plats_d;
            new_color_ball_q  <= new_color_ball_d;
            next_score_q      <= next_score_d;
            gameover_q        <= gameover_d;
            update_done_q     <= update_done_d;
            rand_ack_q        <= rand_ack_d;
`ifdef BOUNCE_COMBO_EN
            combo_q           <= combo_d;
`endif
        end
    end

    assign prev_ball       = prev_ball_q;
    assign new_curr_ball   = new_curr_ball_q;
    assign new_color_plats = new_color_plats_q;
    assign new_color_ball  = new_color_ball_q;
    assign next_score      = next_score_q;
    assign gameover        = gameover_q;
    assign update_done     = update_done_q;
    assign rand_ack        = rand_ack_q;
endmodule

// File: doc/bounce_updater_n.md
# bounce_updater_n

Parametrised per-frame game-state updater for the colour-bounce game. It is the next generation of the 4-platform updater. It supports any number of platform lanes and configurable widths, registers key presses by edge rather than level, and keeps game-over sticky under an explicit FSM. It sits between the game controller, which issues one `step` per frame, and the draw/score datapath, which consumes the registered outputs.

## Interface
- `NUM_LANES`, 4: number of platforms, keys and colour slots.
- `POS_W`, 8: ball/platform vertical position width.
- `COLOR_W`, 3: colour code width.
- `SCORE_W`, 16: score width.
- `SCREEN_H`, 160: a ball position `>= SCREEN_H` is off-screen and ends the game.
- `HIT_WINDOW`, 4: a platform is touching if `curr_ball <= pos <= curr_ball+HIT_WINDOW`.
- `BOUNCE_LEN`, 65: number of rising frames after a hit.
- `clk` in 1: system clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `step` in 1: one-cycle update strobe from the controller.
- `restart` in 1: leaves OVER.
- `keys` in NUM_LANES: active-low lane buttons; lane i pairs with slot i.
- `curr_ball` in POS_W: current ball position.
- `position_plats` in NUM_LANES*POS_W: lane i occupies `[i*POS_W +: POS_W]`.
- `color_plats` in NUM_LANES*COLOR_W: lane i occupies `[i*COLOR_W +: COLOR_W]`.
- `color_ball` in COLOR_W: current ball colour.
- `curr_score` in SCORE_W: current score.
- `rand_plats` in NUM_LANES*COLOR_W: fresh random platform colours from an external source.
- `rand_ball` in COLOR_W: fresh random ball colour from the same source.
- `prev_ball` out POS_W: `curr_ball` as sampled at the last step.
- `new_curr_ball` out POS_W: next ball position.
- `new_color_plats` out NUM_LANES*COLOR_W: next platform colours.
- `new_color_ball` out COLOR_W: next ball colour.
- `next_score` out SCORE_W: next score.
- `gameover` out 1: sticky game-over flag.
- `update_done` out 1: one-cycle pulse when outputs are valid.
- `rand_ack` out 1: one-cycle pulse telling the random source to advance.

## Operation
- **Reset.** All outputs are 0. State is FALL; `up_counter`, `combo`, `pending_valid` and the key history are all 0.
- **Key capture (every cycle, independent of `step`).**
  - `key_q` holds the previous `keys` value.
  - A press on lane i is `key_q[i] & ~keys[i]` (falling edge).
  - A press is captured only when `pending_valid==0`. If several lanes fall in the same cycle, the lowest index wins and the rest are dropped.
  - A held key never generates a second press.
- **FSM states: FALL, RISE, OVER.**
- **On `step` in FALL or RISE:**
  - `prev_ball <= curr_ball`.
  - `pending_valid` clears, whether or not the press is used.
  - Hit test, only in FALL with a pending press on lane i:
    - Colour must match: `color_ball == color_plats` slot i.
    - Position must be in the window, computed at POS_W+1 bits so it cannot wrap.
  - On a hit:
    - `new_color_plats <= rand_plats`, `new_color_ball <= rand_ball`, and `rand_ack` pulses.
    - `up_counter <= BOUNCE_LEN`, next state RISE.
    - Score increment as set under Configuration; `next_score` saturates at all-ones.
  - Otherwise: the colours pass through unchanged and `next_score <= curr_score`.
  - Ball motion:
    - In FALL (including the hit frame): `new_curr_ball <= curr_ball+1`.
    - In RISE: `new_curr_ball <= curr_ball-1`, saturating at 0, and `up_counter` decrements. When it reaches 0 the state returns to FALL.
  - Game over: if the computed position is `>= SCREEN_H` (evaluated at POS_W+1 bits), then `gameover <= 1`, `next_score <= 0`, and the state goes to OVER. This overrides any hit in the same step.
- **In OVER:**
  - `step` is ignored: no `update_done`, outputs hold.
  - `restart` clears `gameover`, `combo` and `pending_valid`, and goes to FALL.
  - `reset` has the same effect as `restart`.

## Timing
- Outputs are registered. `update_done` and `rand_ack` go high in the cycle after `step` and last exactly one cycle.
- Latency from `step` to valid outputs is 1 cycle. `step` may come every cycle.
- A press edge in the same cycle as `step` is captured and used at the *next* step, not the current one.
- `reset` wins over `step` and `restart` in the same cycle.
- `restart` asserted outside OVER has no effect.

## Configuration
- `BOUNCE_COMBO_EN`:
  - **Defined.** A 4-bit `combo` register counts consecutive hits, saturating at 8.
    - On a hit, `combo` increments first, then the score adds the new `combo`.
    - A pending press consumed without a hit (wrong colour or out of window) clears `combo`.
    - Game over clears `combo`.
  - **Undefined.** Each hit adds exactly 1 and no `combo` register exists.

## Test plan
- **Reset:** hold `reset` for 2 cycles -> all outputs 0; a following `step` with `curr_ball=10` gives `new_curr_ball=11` and `prev_ball=10`.
- **Hit:** `color_ball=3`, lane 2 colour 3, pos2=12, `curr_ball=10`; fall edge on `keys[2]`, then `step` -> `new_color_*` equal the `rand_*` inputs, `rand_ack` pulses, `next_score=curr_score+1`, `new_curr_ball=11`, state RISE.
- **Bounce length:** after the hit, 65 steps give `new_curr_ball=curr_ball-1`, then the next step gives `+1`; a press during RISE does not change colours.
- **Held key and simultaneous edges:** `keys[1]` held low for 5 steps -> one press only; lanes 0 and 3 falling in the same cycle -> lane 0 is tested.
- **Game over:** `curr_ball=159` in FALL, `step` -> `gameover=1`, `next_score=0`; further steps give no `update_done`; `restart` -> `gameover=0`.
- **Combo (`BOUNCE_COMBO_EN`):** three consecutive hits from `curr_score=0` -> scores 1, 3, 6; a wrong-colour press, then a hit -> +1.
